// File: rtl/bitplane_dma.sv
// Bitplane DMA sequencer: tracks the DDF fetch window, decodes the lores/hires slot order and
// owns the six bitplane pointers with odd/even modulo.
module bitplane_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:1]  reg_address_in,
  input  logic [15:0] data_in,
  input  logic [8:0]  hpos,
  input  logic        vena,
  input  logic        dmaen,
  output logic        dma,
  output logic [20:1] address_out,
  output logic [8:1]  reg_address_out
);

  localparam logic [8:1] AdrBplcon0 = 8'h80;
  localparam logic [8:1] AdrDdfstrt = 8'h49;
  localparam logic [8:1] AdrDdfstop = 8'h4A;
  localparam logic [8:1] AdrBpl1mod = 8'h84;
  localparam logic [8:1] AdrBpl2mod = 8'h85;
  localparam logic [8:1] AdrBpl1pth = 8'h70;

  typedef enum logic [1:0] {StIdle, StFetch, StLast} state_e;

  state_e      state_q, state_d, cur_st;
  logic        hires_q, hires_d;
  logic [2:0]  bpu_q, bpu_d;
  logic [4:0]  ddfstrt_q, ddfstrt_d, ddfstop_q, ddfstop_d;
  logic [20:1] mod1_q, mod1_d, mod2_q, mod2_d;
  logic [20:1] ptr_q [6];
  logic [20:1] ptr_d [6];

  logic [7:0]  h;
  logic [2:0]  off;
  logic [2:0]  plane, bpu_eff;
  logic        slot_used, final_slot;
  logic [20:1] sel_ptr, inc;

  assign h       = hpos[7:0];
  assign off     = hpos[2:0];
  assign bpu_eff = (bpu_q == 3'd7) ? 3'd0 : bpu_q;

  // cur_st is the window state that applies to the current slot; a group boundary resolves
  // start/stop combinationally so the first slot of a group can already be used.
  always_comb begin
    cur_st = state_q;
    if (off == 3'd0) begin
      cur_st = StIdle;
      if (vena && (state_q == StFetch || (state_q == StIdle && h == {ddfstrt_q, 3'b000}))) begin
        cur_st = (h == {ddfstop_q, 3'b000} || h >= 8'hD8) ? StLast : StFetch;
      end
    end
    state_d = (cur_st == StLast && off == 3'd7) ? StIdle : cur_st;
  end

  always_comb begin
    plane = 3'd0;
    if (hires_q) begin
      unique case (off)
        3'd0, 3'd4: plane = 3'd4;
        3'd1, 3'd5: plane = 3'd2;
        3'd2, 3'd6: plane = 3'd3;
        default:    plane = 3'd1;
      endcase
    end else begin
      unique case (off)
        3'd0, 3'd4: plane = 3'd0;
        3'd1:       plane = 3'd4;
        3'd2:       plane = 3'd6;
        3'd3:       plane = 3'd2;
        3'd5:       plane = 3'd3;
        3'd6:       plane = 3'd5;
        default:    plane = 3'd1;
      endcase
    end
  end

  assign slot_used = dmaen && (cur_st != StIdle) && (plane != 3'd0) && (plane <= bpu_eff) &&
                     (!hires_q || plane <= 3'd4);

  always_comb begin
    sel_ptr = '0;
    for (int i = 0; i < 6; i++) begin
      if (plane == 3'(i + 1)) sel_ptr = ptr_q[i];
    end
  end

  // In hires each plane appears twice per group; only the second slot applies the modulo.
  assign final_slot = (cur_st == StLast) && (!hires_q || off[2]);
  assign inc        = 20'd1 + (final_slot ? (plane[0] ? mod1_q : mod2_q) : 20'd0);

  assign dma             = slot_used;
  assign address_out     = slot_used ? sel_ptr : '0;
  assign reg_address_out = slot_used ? (8'h87 + {5'd0, plane}) : 8'hFF;

  always_comb begin
    hires_d   = hires_q;
    bpu_d     = bpu_q;
    ddfstrt_d = ddfstrt_q;
    ddfstop_d = ddfstop_q;
    mod1_d    = mod1_q;
    mod2_d    = mod2_q;
    case (reg_address_in)
      AdrBplcon0: begin
        hires_d = data_in[15];
        bpu_d   = data_in[14:12];
      end
      AdrDdfstrt: ddfstrt_d = data_in[7:3];
      AdrDdfstop: ddfstop_d = data_in[7:3];
      AdrBpl1mod: mod1_d = {{5{data_in[15]}}, data_in[15:1]};
      AdrBpl2mod: mod2_d = {{5{data_in[15]}}, data_in[15:1]};
      default: ;
    endcase
  end

  // A CPU write to a pointer half overrides any increment from a fetch in the same cycle.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      ptr_d[i] = ptr_q[i];
      if (slot_used && plane == 3'(i + 1)) ptr_d[i] = ptr_q[i] + inc;
      if (reg_address_in == 8'(AdrBpl1pth + 8'(2 * i))) begin
        ptr_d[i] = {data_in[4:0], ptr_q[i][15:1]};
      end else if (reg_address_in == 8'(AdrBpl1pth + 8'(2 * i + 1))) begin
        ptr_d[i] = {ptr_q[i][20:16], data_in[15:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      hires_q   <= 1'b0;
      bpu_q     <= 3'd0;
      ddfstrt_q <= 5'd0;
      ddfstop_q <= 5'd0;
      mod1_q    <= '0;
      mod2_q    <= '0;
      for (int i = 0; i < 6; i++) ptr_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      hires_q   <= hires_d;
      bpu_q     <= bpu_d;
      ddfstrt_q <= ddfstrt_d;
      ddfstop_q <= ddfstop_d;
      mod1_q    <= mod1_d;
      mod2_q    <= mod2_d;
      for (int i = 0; i < 6; i++) ptr_q[i] <= ptr_d[i];
    end
  end

endmodule

// File: tb/tb_bitplane_dma.sv
// Bench for bitplane_dma: a per-line reference model plans every expected fetch into a
// scoreboard queue; a negedge monitor pops and compares whenever dma is raised.
module tb_bitplane_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:1]  reg_address_in;
  logic [15:0] data_in;
  logic [8:0]  hpos;
  logic        vena, dmaen;
  logic        dma;
  logic [20:1] address_out;
  logic [8:1]  reg_address_out;

  always #5 clk = ~clk;

  bitplane_dma dut (
    .clk            (clk),
    .reset          (reset),
    .reg_address_in (reg_address_in),
    .data_in        (data_in),
    .hpos           (hpos),
    .vena           (vena),
    .dmaen          (dmaen),
    .dma            (dma),
    .address_out    (address_out),
    .reg_address_out(reg_address_out)
  );

  typedef struct packed {logic [7:0] h; logic [7:0] r; logic [19:0] a;} exp_t;
  typedef struct packed {logic [7:0] a; logic [15:0] d;} wr_t;

  exp_t sb[$];
  wr_t  wq[$];
  int   errors = 0;
  int   checks = 0;
  int   line_dma;
  logic [19:0] line_first;
  bit   first_seen;

  // Reference model: register view as seen at the start of a line.
  bit          m_hires, m_dmaen;
  int          m_bpu, m_strt, m_stop;
  logic [19:0] m_mod1, m_mod2;
  logic [19:0] m_ptr [1:6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at hpos=%h: got %h, expected %h", name, hpos, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (dma === 1'b1) begin
        exp_t e;
        line_dma++;
        if (!first_seen) begin
          first_seen = 1;
          line_first = address_out;
        end
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch at hpos=%h: got reg %h addr %h, expected none",
                   hpos, reg_address_out, address_out);
        end else begin
          e = sb.pop_front();
          check("fetch_hpos", {24'd0, hpos[7:0]}, {24'd0, e.h});
          check("fetch_reg", {24'd0, reg_address_out}, {24'd0, e.r});
          check("fetch_addr", {12'd0, address_out}, {12'd0, e.a});
        end
      end else begin
        check("idle_reg", {24'd0, reg_address_out}, 32'hFF);
      end
    end
  end

  task automatic model_zero();
    m_hires = 0; m_bpu = 0; m_strt = 0; m_stop = 0;
    m_mod1 = '0; m_mod2 = '0;
    for (int n = 1; n <= 6; n++) m_ptr[n] = '0;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [15:0] d);
    int n;
    wr_t w;
    w.a = a; w.d = d;
    wq.push_back(w);
    case (a)
      8'h80: begin m_hires = d[15]; m_bpu = (d[14:12] == 3'd7) ? 0 : int'(d[14:12]); end
      8'h49: m_strt = int'(d[7:3]);
      8'h4A: m_stop = int'(d[7:3]);
      8'h84: m_mod1 = {{5{d[15]}}, d[15:1]};
      8'h85: m_mod2 = {{5{d[15]}}, d[15:1]};
      default: if (a >= 8'h70 && a <= 8'h7B) begin
        n = int'(a - 8'h70) / 2 + 1;
        if (!a[0]) m_ptr[n][19:15] = d[4:0];
        else       m_ptr[n][14:0]  = d[15:1];
      end
    endcase
  endtask

  task automatic set_ptr(input int n, input logic [19:0] v);
    cfg_write(8'(8'h70 + 2 * (n - 1)), {11'd0, v[19:15]});
    cfg_write(8'(8'h71 + 2 * (n - 1)), {v[14:0], 1'b0});
  endtask

  // Walks one scanline slot by slot, applying the window, slot-order and pointer rules.
  task automatic plan_line(input bit wr_en, input int wr_h, input logic [7:0] wa,
                           input logic [15:0] wd);
    int lo [8] = '{0, 4, 6, 2, 0, 3, 5, 1};
    int hi [8] = '{4, 2, 3, 1, 4, 2, 3, 1};
    bit in_win = 0, last = 0, fin;
    int p, off, n;
    logic [19:0] old [1:6];
    exp_t e;
    for (int h = 0; h < 256; h++) begin
      off = h % 8;
      for (int k = 1; k <= 6; k++) old[k] = m_ptr[k];
      if (off == 0) begin
        if (!in_win && h == m_strt * 8) in_win = 1;
        if (in_win) last = (h == m_stop * 8) || (h >= 216);
      end
      if (in_win && m_dmaen) begin
        p = m_hires ? hi[off] : lo[off];
        if (p != 0 && p <= m_bpu && (!m_hires || p <= 4)) begin
          e.h = 8'(h); e.r = 8'(8'h87 + p); e.a = m_ptr[p];
          sb.push_back(e);
          fin = last && (!m_hires || off >= 4);
          m_ptr[p] = m_ptr[p] + 20'd1 + (fin ? ((p % 2 == 1) ? m_mod1 : m_mod2) : 20'd0);
        end
      end
      if (wr_en && h == wr_h && wa >= 8'h70 && wa <= 8'h7B) begin
        n = int'(wa - 8'h70) / 2 + 1;
        m_ptr[n] = old[n];
        if (!wa[0]) m_ptr[n][19:15] = wd[4:0];
        else        m_ptr[n][14:0]  = wd[15:1];
      end
      if (in_win && last && off == 7) begin
        in_win = 0;
        last = 0;
      end
    end
  endtask

  task automatic step(input int h, input logic v, input logic [7:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    hpos = 9'(h);
    vena = v;
    reg_address_in = a;
    data_in = d;
  endtask

  task automatic run_line(input bit wr_en, input int wr_h, input logic [7:0] wa,
                          input logic [15:0] wd, input int rst_h);
    wr_t w;
    plan_line(wr_en, wr_h, wa, wd);
    for (int i = 0; i < 32; i++) begin
      if (wq.size() != 0) begin
        w = wq.pop_front();
        step(8'hE0 + i, 1'b0, w.a, w.d);
      end else begin
        step(8'hE0 + i, 1'b0, 8'h00, 16'h0000);
      end
      if (i == 0) dmaen = m_dmaen;
    end
    line_dma = 0;
    first_seen = 0;
    for (int h = 0; h < 256; h++) begin
      if (wr_en && h == wr_h) step(h, 1'b1, wa, wd);
      else                    step(h, 1'b1, 8'h00, 16'h0000);
      if (rst_h >= 0 && h == rst_h) begin
        #2;
        reset = 1'b1;
        #1;
        check("rst_dma", {31'd0, dma}, 32'd0);
        check("rst_addr", {12'd0, address_out}, 32'd0);
        check("rst_reg", {24'd0, reg_address_out}, 32'hFF);
        sb.delete();
        model_zero();
      end
      if (rst_h >= 0 && h == rst_h + 1) reset = 1'b0;
    end
    @(negedge clk);
    #1;
    check("line_drained", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    reset = 1'b1;
    hpos = 9'h03F;
    vena = 1'b1;
    dmaen = 1'b1;
    reg_address_in = 8'h00;
    data_in = 16'h0000;
    m_dmaen = 1;
    model_zero();
    #1;
    check("reset_dma", {31'd0, dma}, 32'd0);
    check("reset_addr", {12'd0, address_out}, 32'd0);
    check("reset_reg", {24'd0, reg_address_out}, 32'hFF);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Lores, one plane, full window.
    cfg_write(8'h80, 16'h1000);
    cfg_write(8'h49, 16'h0038);
    cfg_write(8'h4A, 16'h00D0);
    cfg_write(8'h84, 16'h0000);
    cfg_write(8'h85, 16'h0000);
    set_ptr(1, 20'h10000);
    run_line(0, 0, 8'h00, 16'h0000, -1);
    check("lores_count", line_dma, 32'd20);
    check("lores_first", {12'd0, line_first}, 32'h10000);

    // Odd modulo applied on the final fetch, visible on the next line.
    cfg_write(8'h84, 16'h0028);
    set_ptr(1, 20'h10000);
    run_line(0, 0, 8'h00, 16'h0000, -1);
    check("mod_count", line_dma, 32'd20);
    run_line(0, 0, 8'h00, 16'h0000, -1);
    check("mod_next_line", {12'd0, line_first}, 32'h10028);

    // Lores six planes, single group (ddfstrt == ddfstop).
    cfg_write(8'h80, 16'h6000);
    cfg_write(8'h4A, 16'h0038);
    for (int n = 1; n <= 6; n++) set_ptr(n, 20'(n * 20'h01000));
    run_line(0, 0, 8'h00, 16'h0000, -1);
    check("six_plane_count", line_dma, 32'd6);

    // Hires four planes with negative even modulo.
    cfg_write(8'h80, 16'hC000);
    cfg_write(8'h84, 16'h0000);
    cfg_write(8'h85, 16'hFFFE);
    run_line(0, 0, 8'h00, 16'h0000, -1);
    check("hires_count", line_dma, 32'd8);
    run_line(0, 0, 8'h00, 16'h0000, -1);

    // PTL write colliding with a plane-1 fetch.
    cfg_write(8'h80, 16'h1000);
    cfg_write(8'h4A, 16'h00D0);
    set_ptr(1, 20'h00000);
    run_line(1, 8'h47, 8'h71, 16'h2000, -1);

    // ddfstop never reached: hard stop at 0xD8.
    cfg_write(8'h4A, 16'h0010);
    run_line(0, 0, 8'h00, 16'h0000, -1);
    check("hard_stop_count", line_dma, 32'd21);

    // Asynchronous reset mid-fetch, then nothing until registers are rewritten.
    cfg_write(8'h80, 16'h6000);
    cfg_write(8'h4A, 16'h00D0);
    run_line(0, 0, 8'h00, 16'h0000, 8'h50);
    run_line(0, 0, 8'h00, 16'h0000, -1);
    check("post_reset_count", line_dma, 32'd0);

    for (int k = 0; k < 24; k++) begin
      bit wr_en;
      int wr_h, wp;
      logic [7:0] wa;
      cfg_write(8'h80, 16'($urandom));
      cfg_write(8'h49, 16'($urandom_range(0, 255)));
      cfg_write(8'h4A, 16'($urandom_range(0, 255)));
      cfg_write(8'h84, 16'($urandom));
      cfg_write(8'h85, 16'($urandom));
      for (int n = 1; n <= 6; n++) if ($urandom_range(0, 1) == 1) set_ptr(n, 20'($urandom));
      m_dmaen = ($urandom_range(0, 7) != 0);
      wr_en = ($urandom_range(0, 1) == 1);
      wr_h = $urandom_range(0, 255);
      wp = $urandom_range(0, 11);
      wa = 8'(8'h70 + wp);
      run_line(wr_en, wr_h, wa, 16'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
